// File: rtl/alu_issue.sv
// alu_issue: two-stage (decode/read, ALU drive/writeback) R-type issue controller for an external combinational ALU.
// Optional macro ALU_ISSUE_FORWARD_EN: forward live alu_result on RAW hazards instead of stalling one cycle.
module alu_issue #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_src_1,
    output logic [31:0] alu_src_2,
    output logic [4:0]  alu_shamt,
    output logic [1:0]  alu_funct,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic {ST_RESET, ST_RUN} state_t;

    state_t      state, state_next;
    logic [31:0] regs [NREG];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        legal, is_sll;
    logic [1:0]  dec_funct;

    logic        e_valid;
    logic [31:0] e_src_1, e_src_2;
    logic [4:0]  e_shamt, e_rd;
    logic [1:0]  e_funct;

    logic        rs_hit, rt_hit, hazard, accept;
    logic [31:0] rs_val, rt_val, d_src_1, d_src_2;
    logic [4:0]  d_shamt;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_RESET) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        dec_funct = 2'b00;
        legal     = 1'b0;
        if (op == 6'd0) begin
            case (funct)
                6'h20: begin dec_funct = 2'b00; legal = 1'b1; end
                6'h22: begin dec_funct = 2'b01; legal = 1'b1; end
                6'h00: begin dec_funct = 2'b10; legal = 1'b1; end
                6'h25: begin dec_funct = 2'b11; legal = 1'b1; end
                default: begin dec_funct = 2'b00; legal = 1'b0; end
            endcase
        end
    end

    assign is_sll = legal && (dec_funct == 2'b10);

    // sll reads only rt, so an rs match must not create a hazard for it; R0 never hazards.
    assign rs_hit = e_valid && (e_rd != 5'd0) && legal && !is_sll && (rs == e_rd);
    assign rt_hit = e_valid && (e_rd != 5'd0) && legal && (rt == e_rd);
    assign hazard = rs_hit || rt_hit;

`ifdef ALU_ISSUE_FORWARD_EN
    assign instr_ready = (state == ST_RUN);
`else
    assign instr_ready = (state == ST_RUN) && !hazard;
`endif

    assign accept = instr_valid && instr_ready;

    always_comb begin
        rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
        rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];
        d_src_1 = 32'd0;
        d_src_2 = 32'd0;
        d_shamt = 5'd0;
`ifdef ALU_ISSUE_FORWARD_EN
        if (rs_hit) rs_val = alu_result;
        if (rt_hit) rt_val = alu_result;
`endif
        if (is_sll) begin
            d_src_1 = rt_val;
            d_shamt = shamt;
        end else begin
            d_src_1 = rs_val;
            d_src_2 = rt_val;
        end
    end

    // E-stage registers are zeroed whenever empty so the ALU port reads 0 without extra gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid  <= 1'b0;
            e_src_1  <= 32'd0;
            e_src_2  <= 32'd0;
            e_shamt  <= 5'd0;
            e_funct  <= 2'b00;
            e_rd     <= 5'd0;
            wb_valid <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            illegal  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            e_valid <= accept && legal;
            if (accept && legal) begin
                e_src_1 <= d_src_1;
                e_src_2 <= d_src_2;
                e_shamt <= d_shamt;
                e_funct <= dec_funct;
                e_rd    <= rd;
            end else begin
                e_src_1 <= 32'd0;
                e_src_2 <= 32'd0;
                e_shamt <= 5'd0;
                e_funct <= 2'b00;
                e_rd    <= 5'd0;
            end
            illegal  <= accept && !legal;
            wb_valid <= e_valid;
            wb_addr  <= e_valid ? e_rd : 5'd0;
            wb_data  <= e_valid ? alu_result : 32'd0;
            // Writeback is assigned last so it overrides a preload to the same register.
            if (ld_en && (ld_addr != 5'd0)) begin
                regs[ld_addr] <= ld_data;
            end
            if (e_valid && (e_rd != 5'd0)) begin
                regs[e_rd] <= alu_result;
            end
        end
    end

    assign alu_src_1 = e_src_1;
    assign alu_src_2 = e_src_2;
    assign alu_shamt = e_shamt;
    assign alu_funct = e_funct;
    assign dbg_data  = regs[dbg_addr];

endmodule
